// File: rtl/bits_pkg.sv
// Shared definitions for the BITS stack memory controller.
package bits_pkg;

   localparam int SMEM_AW = 14;
   localparam int SMEM_DW = 96;

   localparam logic STK_PUSH = 1'b0;
   localparam logic STK_POP  = 1'b1;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_WRITE = 4'd1,
      ST_READ  = 4'd2,
      ST_RWAIT = 4'd3,
      ST_ACK   = 4'd4,
      ST_ERR   = 4'd5
   } stk_state_t;

endpackage

// File: rtl/bits_rr_arb2.sv
// Two-way round-robin arbiter; last_grant only moves on a real conflict.
module bits_rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       grant_en,
   output logic [1:0] grant
);

   logic last_grant;

   always_comb begin
      grant = 2'b00;
      if (grant_en) begin
         case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         last_grant <= 1'b1;
      else if (grant_en && (&req))
         last_grant <= grant[1];
   end

endmodule

// File: rtl/bits_stack_ctrl.sv
// BITS stack controller: arbitrates two push/pop requesters onto a
// single-port stack memory and owns the stack pointer.
//
//   state | meaning
//   IDLE  | apply pending clear, else arbitrate and launch an access
//   WRITE | memory write cycle in progress, bump sp
//   READ  | memory read cycle issued, arm latency counter
//   RWAIT | wait for read data, capture it and drop sp
//   ACK   | pulse ack with err=0
//   ERR   | pulse ack with err=1 (overflow / underflow), no access made
module bits_stack_ctrl
   import bits_pkg::*;
#(
   parameter int AW     = SMEM_AW,
   parameter int DW     = SMEM_DW,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          r0_req,
   input  logic          r0_op,
   input  logic [DW-1:0] r0_wdata,
   output logic          r0_ack,
   output logic          r0_err,
   output logic [DW-1:0] r0_rdata,
   input  logic          r1_req,
   input  logic          r1_op,
   input  logic [DW-1:0] r1_wdata,
   output logic          r1_ack,
   output logic          r1_err,
   output logic [DW-1:0] r1_rdata,
   input  logic          clear,
   output logic          smem_ceb,
   output logic          smem_web,
   output logic [AW-1:0] smem_addr,
   output logic [DW-1:0] smem_wdata,
   input  logic [DW-1:0] smem_rdata,
   output logic [AW:0]   sp,
   output logic          empty,
   output logic          full,
   output logic          busy
);

   localparam logic [AW:0]   SP_ONE   = 1;
   localparam logic [AW:0]   CAP      = SP_ONE << AW;
   localparam logic [AW-1:0] ADDR_ONE = 1;
   localparam logic [1:0]    CNT_INIT = 2'(RD_LAT - 1);

   stk_state_t    state;
   logic          gnt_id;
   logic [1:0]    cnt;
   logic          clear_pend;
   logic [1:0]    req_m;
   logic [1:0]    grant;
   logic          grant_en;
   logic          sel_op;
   logic [DW-1:0] sel_wdata;

   // A requester is still high during its own ack cycle; ignore it then.
   assign req_m     = {r1_req & ~r1_ack, r0_req & ~r0_ack};
   assign grant_en  = (state == ST_IDLE) && !clear && !clear_pend;
   assign sel_op    = grant[1] ? r1_op : r0_op;
   assign sel_wdata = grant[1] ? r1_wdata : r0_wdata;

   bits_rr_arb2 u_arb (
      .clk      (clk),
      .reset    (reset),
      .req      (req_m),
      .grant_en (grant_en),
      .grant    (grant)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         gnt_id     <= 1'b0;
         cnt        <= '0;
         clear_pend <= 1'b0;
         smem_ceb   <= 1'b1;
         smem_web   <= 1'b1;
         smem_addr  <= '0;
         smem_wdata <= '0;
         r0_ack     <= 1'b0;
         r0_err     <= 1'b0;
         r0_rdata   <= '0;
         r1_ack     <= 1'b0;
         r1_err     <= 1'b0;
         r1_rdata   <= '0;
         sp         <= '0;
         empty      <= 1'b1;
         full       <= 1'b0;
         busy       <= 1'b0;
      end else begin
         r0_ack <= 1'b0;
         r0_err <= 1'b0;
         r1_ack <= 1'b0;
         r1_err <= 1'b0;
         if (clear && state != ST_IDLE)
            clear_pend <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (clear || clear_pend) begin
                  sp         <= '0;
                  empty      <= 1'b1;
                  full       <= 1'b0;
                  clear_pend <= 1'b0;
               end else if (|grant) begin
                  gnt_id <= grant[1];
                  busy   <= 1'b1;
                  if (sel_op == STK_PUSH) begin
                     if (full) begin
                        state <= ST_ERR;
                     end else begin
                        state      <= ST_WRITE;
                        smem_ceb   <= 1'b0;
                        smem_web   <= 1'b0;
                        smem_addr  <= sp[AW-1:0];
                        smem_wdata <= sel_wdata;
                     end
                  end else begin
                     if (empty) begin
                        state <= ST_ERR;
                     end else begin
                        state     <= ST_READ;
                        smem_ceb  <= 1'b0;
                        smem_web  <= 1'b1;
                        smem_addr <= sp[AW-1:0] - ADDR_ONE;
                     end
                  end
               end
            end
            ST_WRITE: begin
               sp       <= sp + SP_ONE;
               empty    <= 1'b0;
               full     <= (sp + SP_ONE) == CAP;
               smem_ceb <= 1'b1;
               smem_web <= 1'b1;
               state    <= ST_ACK;
            end
            ST_READ: begin
               smem_ceb <= 1'b1;
               cnt      <= CNT_INIT;
               state    <= ST_RWAIT;
            end
            ST_RWAIT: begin
               if (cnt == 2'd0) begin
                  if (gnt_id) r1_rdata <= smem_rdata;
                  else        r0_rdata <= smem_rdata;
                  sp    <= sp - SP_ONE;
                  full  <= 1'b0;
                  empty <= (sp == SP_ONE);
                  state <= ST_ACK;
               end else begin
                  cnt <= cnt - 2'd1;
               end
            end
            ST_ACK: begin
               if (gnt_id) r1_ack <= 1'b1;
               else        r0_ack <= 1'b1;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            ST_ERR: begin
               if (gnt_id) begin
                  r1_ack <= 1'b1;
                  r1_err <= 1'b1;
               end else begin
                  r0_ack <= 1'b1;
                  r0_err <= 1'b1;
               end
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bits_stack_ctrl.sv
// Directed bench: instance A (AW=2, RD_LAT=1) and instance B (AW=4, RD_LAT=3).
module tb_bits_stack_ctrl;

   localparam logic PUSH = 1'b0;
   localparam logic POP  = 1'b1;

   logic clk = 1'b0;
   logic rst_a, rst_b;
   always #5 clk = ~clk;

   logic        req  [2][2];
   logic        op   [2][2];
   logic [95:0] wd   [2][2];
   logic        ack  [2][2];
   logic        err  [2][2];
   logic [95:0] rdat [2][2];
   logic        clr  [2];

   logic        ceb_a, web_a, empty_a, full_a, busy_a;
   logic [1:0]  addr_a;
   logic [95:0] wdata_a, rd_a;
   logic [2:0]  sp_a;
   logic        ceb_b, web_b, empty_b, full_b, busy_b;
   logic [3:0]  addr_b;
   logic [95:0] wdata_b, rd_b, p1_b, p2_b;
   logic [4:0]  sp_b;

   logic [95:0] mem_a [4];
   logic [95:0] mem_b [16];

   int checks = 0;
   int failures = 0;

   bits_stack_ctrl #(.AW(2), .DW(96), .RD_LAT(1)) u_a (
      .clk(clk), .reset(rst_a),
      .r0_req(req[0][0]), .r0_op(op[0][0]), .r0_wdata(wd[0][0]),
      .r0_ack(ack[0][0]), .r0_err(err[0][0]), .r0_rdata(rdat[0][0]),
      .r1_req(req[0][1]), .r1_op(op[0][1]), .r1_wdata(wd[0][1]),
      .r1_ack(ack[0][1]), .r1_err(err[0][1]), .r1_rdata(rdat[0][1]),
      .clear(clr[0]), .smem_ceb(ceb_a), .smem_web(web_a), .smem_addr(addr_a),
      .smem_wdata(wdata_a), .smem_rdata(rd_a), .sp(sp_a), .empty(empty_a),
      .full(full_a), .busy(busy_a)
   );

   bits_stack_ctrl #(.AW(4), .DW(96), .RD_LAT(3)) u_b (
      .clk(clk), .reset(rst_b),
      .r0_req(req[1][0]), .r0_op(op[1][0]), .r0_wdata(wd[1][0]),
      .r0_ack(ack[1][0]), .r0_err(err[1][0]), .r0_rdata(rdat[1][0]),
      .r1_req(req[1][1]), .r1_op(op[1][1]), .r1_wdata(wd[1][1]),
      .r1_ack(ack[1][1]), .r1_err(err[1][1]), .r1_rdata(rdat[1][1]),
      .clear(clr[1]), .smem_ceb(ceb_b), .smem_web(web_b), .smem_addr(addr_b),
      .smem_wdata(wdata_b), .smem_rdata(rd_b), .sp(sp_b), .empty(empty_b),
      .full(full_b), .busy(busy_b)
   );

   // memory models: A has 1-cycle read latency, B has 3
   always @(posedge clk) begin
      if (!ceb_a && !web_a) mem_a[addr_a] <= wdata_a;
      if (!ceb_a && web_a)  rd_a <= mem_a[addr_a];
      if (!ceb_b && !web_b) mem_b[addr_b] <= wdata_b;
      p1_b <= (!ceb_b && web_b) ? mem_b[addr_b] : 96'h0;
      p2_b <= p1_b;
      rd_b <= p2_b;
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // steps negedges until ack of (inst,id); optional one-cycle clear pulse at step clr_at
   task automatic wait_ack(input int inst, input int id, input int clr_at,
                           output int n, output logic ceb_low);
      logic seen;
      seen = 1'b0;
      n = 0;
      ceb_low = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         clr[inst] = (k == clr_at);
         if ((inst == 0) ? !ceb_a : !ceb_b) ceb_low = 1'b1;
         if (ack[inst][id]) begin
            n = k;
            seen = 1'b1;
            break;
         end
      end
      clr[inst] = 1'b0;
      check("ack_seen", seen, 1'b1);
   endtask

   task automatic do_op(input int inst, input int id, input logic opv, input logic [95:0] wdv,
                        input int clr_at, output int lat, output logic errv,
                        output logic [95:0] rdv, output logic ceb_low);
      @(negedge clk);
      op[inst][id]  = opv;
      wd[inst][id]  = wdv;
      req[inst][id] = 1'b1;
      wait_ack(inst, id, clr_at, lat, ceb_low);
      errv = err[inst][id];
      rdv  = rdat[inst][id];
      req[inst][id] = 1'b0;
   endtask

   int          lat;
   logic        e, cl, any_ack;
   logic [95:0] rd;

   initial begin
      for (int i = 0; i < 2; i++) begin
         clr[i] = 1'b0;
         for (int j = 0; j < 2; j++) begin
            req[i][j] = 1'b0; op[i][j] = 1'b0; wd[i][j] = '0;
         end
      end
      rst_a = 1'b1;
      rst_b = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_ceb", ceb_a, 1'b1);
      check("rst_web", web_a, 1'b1);
      check("rst_addr", addr_a, 2'd0);
      check("rst_sp", sp_a, 3'd0);
      check("rst_empty", empty_a, 1'b1);
      check("rst_full", full_a, 1'b0);
      check("rst_busy", busy_a, 1'b0);
      check("rst_ack", ack[0][0], 1'b0);
      rst_a = 1'b0;
      rst_b = 1'b0;

      // basic LIFO on r0
      do_op(0, 0, PUSH, 96'hA5, 0, lat, e, rd, cl);
      check("push1_lat", lat, 3); check("push1_err", e, 1'b0); check("push1_sp", sp_a, 3'd1);
      do_op(0, 0, PUSH, 96'h5A, 0, lat, e, rd, cl);
      check("push2_lat", lat, 3); check("push2_sp", sp_a, 3'd2);
      do_op(0, 0, POP, 96'h0, 0, lat, e, rd, cl);
      check("pop1_lat", lat, 4); check("pop1_err", e, 1'b0);
      check("pop1_data", rd, 96'h5A); check("pop1_sp", sp_a, 3'd1);
      do_op(0, 0, POP, 96'h0, 0, lat, e, rd, cl);
      check("pop2_data", rd, 96'hA5); check("pop2_sp", sp_a, 3'd0);
      check("pop2_empty", empty_a, 1'b1);

      // underflow
      do_op(0, 0, POP, 96'h0, 0, lat, e, rd, cl);
      check("uf_lat", lat, 2); check("uf_err", e, 1'b1);
      check("uf_noaccess", cl, 1'b0); check("uf_sp", sp_a, 3'd0);

      // conflict 1: both push, r0 wins
      @(negedge clk);
      op[0][0] = PUSH; wd[0][0] = 96'h11; req[0][0] = 1'b1;
      op[0][1] = PUSH; wd[0][1] = 96'h22; req[0][1] = 1'b1;
      @(negedge clk);
      check("cf1_ceb0", ceb_a, 1'b0); check("cf1_addr0", addr_a, 2'd0);
      wait_ack(0, 0, 0, lat, cl);
      check("cf1_lat0", lat, 2);
      req[0][0] = 1'b0;
      @(negedge clk);
      check("cf1_ceb1", ceb_a, 1'b0); check("cf1_addr1", addr_a, 2'd1);
      wait_ack(0, 1, 0, lat, cl);
      req[0][1] = 1'b0;
      check("cf1_sp", sp_a, 3'd2);

      // conflict 2: both pop, r1 wins this time
      @(negedge clk);
      op[0][0] = POP; req[0][0] = 1'b1;
      op[0][1] = POP; req[0][1] = 1'b1;
      @(negedge clk);
      check("cf2_addr", addr_a, 2'd1); check("cf2_web", web_a, 1'b1);
      wait_ack(0, 1, 0, lat, cl);
      check("cf2_r0_wait", ack[0][0], 1'b0);
      check("cf2_r1_data", rdat[0][1], 96'h22);
      req[0][1] = 1'b0;
      wait_ack(0, 0, 0, lat, cl);
      check("cf2_r0_data", rdat[0][0], 96'h11);
      req[0][0] = 1'b0;
      check("cf2_sp", sp_a, 3'd0);

      // fill AW=2 stack, then overflow
      for (int i = 1; i <= 4; i++) begin
         do_op(0, 0, PUSH, 96'(i), 0, lat, e, rd, cl);
         check("fill_err", e, 1'b0);
      end
      check("fill_sp", sp_a, 3'd4); check("fill_full", full_a, 1'b1);
      do_op(0, 0, PUSH, 96'h99, 0, lat, e, rd, cl);
      check("of_lat", lat, 2); check("of_err", e, 1'b1);
      check("of_noaccess", cl, 1'b0); check("of_sp", sp_a, 3'd4);
      check("of_full", full_a, 1'b1);

      // clear while r1 pop in flight at sp=3
      do_op(0, 0, POP, 96'h0, 0, lat, e, rd, cl);
      check("pre_clr_data", rd, 96'h4); check("pre_clr_sp", sp_a, 3'd3);
      do_op(0, 1, POP, 96'h0, 1, lat, e, rd, cl);
      check("clr_lat", lat, 4); check("clr_err", e, 1'b0);
      check("clr_data", rd, 96'h3); check("clr_sp_ack", sp_a, 3'd2);
      @(negedge clk);
      check("clr_sp", sp_a, 3'd0); check("clr_empty", empty_a, 1'b1);

      // instance B, RD_LAT=3
      do_op(1, 0, PUSH, 96'h1234, 0, lat, e, rd, cl);
      check("b_push_lat", lat, 3);
      do_op(1, 0, POP, 96'h0, 0, lat, e, rd, cl);
      check("b_pop_lat", lat, 6); check("b_pop_data", rd, 96'h1234);
      check("b_pop_sp", sp_b, 5'd0);

      // reset during RWAIT
      do_op(1, 0, PUSH, 96'h77, 0, lat, e, rd, cl);
      check("b_push2_sp", sp_b, 5'd1);
      @(negedge clk);
      op[1][0] = POP; req[1][0] = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_mid_busy_pre", busy_b, 1'b1);
      rst_b = 1'b1;
      #1;
      check("rst_mid_ceb", ceb_b, 1'b1);
      check("rst_mid_busy", busy_b, 1'b0);
      check("rst_mid_sp", sp_b, 5'd0);
      check("rst_mid_empty", empty_b, 1'b1);
      check("rst_mid_rdata", rdat[1][0], 96'h0);
      @(negedge clk);
      req[1][0] = 1'b0;
      rst_b = 1'b0;
      any_ack = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (ack[1][0] || ack[1][1]) any_ack = 1'b1;
      end
      check("rst_mid_noack", any_ack, 1'b0);
      check("rst_mid_sp_after", sp_b, 5'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bits_stack_ctrl.md
Name: bits_stack_ctrl

Overview:
Controller and arbiter for the single-port BITS stack memory (smem, 96-bit words, 14-bit address). It shares the memory between two requesters: requester 0 is the packet decode FSM, requester 1 is the operator evaluator. It owns the stack pointer and converts push/pop requests into smem chip-enable, write-enable, address and data cycles. It also reports full/empty and flags overflow and underflow.

Parameters:
AW, 14, smem address width; capacity is 2^AW entries
DW, 96, stack word width
RD_LAT, 1, smem read latency in cycles from the ceb-low cycle to smem_rdata valid; legal range 1..3

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
r0_req  in  1  requester 0 request; held high until r0_ack
r0_op  in  1  0 = push, 1 = pop; stable while r0_req is high
r0_wdata  in  DW  push data; stable while r0_req is high
r0_ack  out  1  one-cycle completion pulse
r0_err  out  1  valid with r0_ack; overflow (push) or underflow (pop)
r0_rdata  out  DW  pop data; valid with r0_ack, held until the next r0 pop ack
r1_req, r1_op, r1_wdata, r1_ack, r1_err, r1_rdata  same as r0, for requester 1
clear  in  1  flush request; sets the stack pointer to 0
smem_ceb  out  1  memory chip enable, active low
smem_web  out  1  memory write enable, active low
smem_addr  out  AW  memory address
smem_wdata  out  DW  memory write data
smem_rdata  in  DW  memory read data
sp  out  AW+1  current entry count
empty  out  1  sp == 0
full  out  1  sp == 2^AW
busy  out  1  state != IDLE

Behaviour:
- Reset values: smem_ceb=1, smem_web=1, smem_addr=0, smem_wdata=0, r*_ack=0, r*_err=0, r*_rdata=0, sp=0, empty=1, full=0, busy=0, state=IDLE, last_grant=1 (so r0 wins the first conflict).
- All outputs are registered.
- Reset asserted mid-operation drops the in-flight operation immediately: no ack is issued and sp is not updated.
- States: IDLE, WRITE, READ, RWAIT, ACK, ERR.
- IDLE:
  - If clear is high, set sp to 0 and stay in IDLE. clear has priority over requests in the same cycle; requests are not granted that cycle.
  - Otherwise arbitrate r0_req/r1_req. A single request is granted directly. On a conflict, grant the requester not in last_grant, then update last_grant.
  - Push, not full: go to WRITE; next cycle smem_ceb=0, smem_web=0, smem_addr=sp[AW-1:0], smem_wdata=wdata.
  - Pop, not empty: go to READ; next cycle smem_ceb=0, smem_web=1, smem_addr=sp-1.
  - Push when full, or pop when empty: go to ERR with no memory access.
- WRITE (1 cycle): sp <= sp+1, release ceb/web, go to ACK.
- READ (1 cycle): release ceb. Load the wait counter with RD_LAT-1 and go to RWAIT; if RD_LAT=1, go straight to capture.
- RWAIT: decrement the counter. When smem_rdata is valid, capture it into the granted r*_rdata, set sp <= sp-1, go to ACK.
- ACK: pulse the granted r*_ack with err=0, return to IDLE.
- ERR: pulse the granted r*_ack with err=1, return to IDLE; sp unchanged.
- Latency from grant (IDLE sampling req) to ack:
  - push: 3 cycles
  - pop: 3+RD_LAT cycles
  - error: 2 cycles
- A requester may reassert req no earlier than the cycle after its ack. One operation is in flight at a time.
- clear asserted while busy is held pending and applied in the first IDLE cycle after the current ack. The in-flight operation completes normally.
- Pop data comes from the last pushed word (LIFO).
- The sp counter does not wrap; overflow/underflow is reported only through err.

Decomposition:
- Shared package bits_pkg holds:
  - STK_PUSH=1'b0, STK_POP=1'b1
  - state encodings (4-bit)
  - SMEM_AW=14, SMEM_DW=96
- Sub-module bits_rr_arb2: 2-way round-robin arbiter with inputs req[1:0], a grant-enable strobe and last_grant state, and a one-hot grant output.

Test Plan:
- r0 pushes 96'hA5 then 96'h5A, then pops twice -> acks with err=0; rdata 96'h5A then 96'hA5; sp goes 0,1,2,1,0; empty=1 at the end; pop ack arrives 4 cycles after grant with RD_LAT=1.
- r0 and r1 both push in the same cycle after reset -> r0 is granted first (smem_addr=0), then r1 (smem_addr=1); a second conflict grants r1 first.
- Pop with sp=0 -> ack+err 2 cycles after grant, smem_ceb stays 1, sp=0. Push with sp forced full (AW=2 build, 4 pushes) -> the 5th push gets err=1 and full=1.
- clear pulsed during an in-flight r1 pop with sp=3 -> the pop completes with sp=2 and correct data; the next IDLE cycle sets sp=0 and empty=1.
- reset asserted in the RWAIT cycle of a pop (RD_LAT=3) -> all outputs take reset values asynchronously, no ack appears, sp=0.
- RD_LAT=3 build: push 96'h1234 then pop -> rdata=96'h1234, ack 6 cycles after grant.
